// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous-comparison FIFO pointer stages.
package fifo_pkg;

    localparam int unsigned ASIZE_DEFAULT = 4;
    localparam int unsigned DSIZE_DEFAULT = 8;

    // Callers truncate the result to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// One-entry skid buffer in front of an output register; ready depends only on flops.
module skid_buffer #(
    parameter int unsigned DSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] in_data,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    input  logic             take
);

    logic             skid_valid, skid_valid_next, out_valid_next;
    logic [DSIZE-1:0] skid_data, skid_data_next, out_data_next;
    logic             out_free, accept;

    assign in_ready = ~skid_valid;
    assign out_free = ~out_valid | take;
    assign accept   = in_valid & in_ready;

    always_comb begin
        skid_valid_next = skid_valid;
        skid_data_next  = skid_data;
        out_valid_next  = out_valid;
        out_data_next   = out_data;
        if (skid_valid && out_free) begin
            out_data_next   = skid_data;
            out_valid_next  = 1'b1;
            skid_valid_next = 1'b0;
        end else if (accept && out_free) begin
            out_data_next  = in_data;
            out_valid_next = 1'b1;
        end else if (accept) begin
            // Output stage is occupied and stalled: park the beat.
            skid_data_next  = in_data;
            skid_valid_next = 1'b1;
        end else if (take) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            skid_valid <= skid_valid_next;
            out_valid  <= out_valid_next;
        end
    end

    always_ff @(posedge clk) begin
        skid_data <= skid_data_next;
        out_data  <= out_data_next;
    end

endmodule

// File: rtl/wptr_full_skid.sv
// Write-side FIFO controller: skid-buffered upstream, write port drive, Gray pointer
// and wclk-synchronised full flag from the async comparator.
module wptr_full_skid
    import fifo_pkg::*;
#(
    parameter int unsigned ASIZE = ASIZE_DEFAULT,
    parameter int unsigned DSIZE = DSIZE_DEFAULT
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DSIZE-1:0] s_data,
    input  logic             afull_n,
    output logic             wfull,
    output logic [ASIZE-1:0] wptr,
    output logic [ASIZE-1:0] waddr,
    output logic [DSIZE-1:0] wdata,
    output logic             wen
);

    logic             out_valid;
    logic             wfull2;
    logic [ASIZE-1:0] wbin, wbnext, wgnext;

    assign wen   = out_valid & ~wfull;
    assign waddr = wbin;

    skid_buffer #(
        .DSIZE(DSIZE)
    ) u_skid (
        .clk      (wclk),
        .rst      (wrst),
        .in_valid (s_valid),
        .in_ready (s_ready),
        .in_data  (s_data),
        .out_valid(out_valid),
        .out_data (wdata),
        .take     (wen)
    );

    always_comb begin
        wbnext = wbin + ASIZE'(wen);
        wgnext = ASIZE'(bin2gray(32'(wbnext)));
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin <= '0;
            wptr <= '0;
        end else begin
            wbin <= wbnext;
            wptr <= wgnext;
        end
    end

    // Full asserts asynchronously; release is retimed through two wclk edges.
    always_ff @(posedge wclk or posedge wrst or negedge afull_n) begin
        if (wrst) begin
            {wfull, wfull2} <= 2'b00;
        end else if (!afull_n) begin
            {wfull, wfull2} <= 2'b11;
        end else begin
            {wfull, wfull2} <= {wfull2, ~afull_n};
        end
    end

endmodule

// File: tb/tb_wptr_full_skid.sv
// Self-checking bench for wptr_full_skid against a queue-based occupancy model.
module tb_wptr_full_skid;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       afull_n = 1'b1;
    logic       wfull;
    logic [3:0] wptr;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       wen;

    wptr_full_skid #(
        .ASIZE(4),
        .DSIZE(8)
    ) dut (
        .wclk   (wclk),
        .wrst   (wrst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .afull_n(afull_n),
        .wfull  (wfull),
        .wptr   (wptr),
        .waddr  (waddr),
        .wdata  (wdata),
        .wen    (wen)
    );

    always #5 wclk = ~wclk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    int         wcount = 0;
    int         rel_edges = 2;
    int         pushed = 0;

    function automatic logic [3:0] gray_of(input int n);
        int b;
        b = n % 16;
        return 4'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wcount    = 0;
        rel_edges = 2;
    endtask

    // Called at posedge+1: drive, check at negedge, advance model across next posedge.
    task automatic step(input logic v, input logic [7:0] d, input logic an);
        logic full_exp, wen_exp, rdy_exp, acc;
        s_valid = v;
        s_data  = d;
        afull_n = an;
        if (!an) rel_edges = 0;
        @(negedge wclk);
        full_exp = !an || (rel_edges < 2);
        wen_exp  = (q.size() > 0) && !full_exp;
        rdy_exp  = (q.size() < 2);
        chk("wfull", 32'(wfull), 32'(full_exp));
        chk("wen", 32'(wen), 32'(wen_exp));
        chk("s_ready", 32'(s_ready), 32'(rdy_exp));
        chk("waddr", 32'(waddr), 32'(wcount % 16));
        chk("wptr", 32'(wptr), 32'(gray_of(wcount)));
        if (wen_exp) chk("wdata", 32'(wdata), 32'(q[0]));
        acc = v && rdy_exp;
        @(posedge wclk);
        #1;
        if (an && rel_edges < 2) rel_edges++;
        if (wen_exp) begin
            void'(q.pop_front());
            wcount++;
        end
        if (acc) begin
            q.push_back(d);
            pushed++;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        chk("drain_bound", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int start;
        // Reset held with s_valid asserted
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk);
            chk("rst_s_ready", 32'(s_ready), 32'd1);
            chk("rst_wen", 32'(wen), 32'd0);
            chk("rst_wptr", 32'(wptr), 32'd0);
            chk("rst_wfull", 32'(wfull), 32'd0);
        end
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        model_reset();

        // Single write
        step(1'b1, 8'hA5, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("single_waddr", 32'(waddr), 32'd1);
        chk("single_wptr", 32'(wptr), 32'b0001);

        // Stream 17 beats across the wrap
        for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b1);
        drain();

        // Full stall mid-stream, then release
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        chk("stall_s_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b1);
        drain();

        // Async reset mid-stall
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
        chk("pre_rst_wptr_nonzero", 32'(wptr != 4'd0), 32'd1);
        #2;
        wrst = 1'b1;
        #1;
        chk("arst_wen", 32'(wen), 32'd0);
        chk("arst_wfull", 32'(wfull), 32'd0);
        chk("arst_wptr", 32'(wptr), 32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd1);
        afull_n = 1'b1;
        s_valid = 1'b0;
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        model_reset();

        // Toggling full every 3 cycles, 40 beats
        start = pushed;
        for (int c = 0; (pushed - start) < 40 && c < 400; c++)
            step(1'b1, 8'($urandom), ((c / 3) % 2) == 1);
        chk("toggle_beats", 32'(pushed - start), 32'd40);
        drain();

        // Random traffic
        for (int c = 0; c < 200; c++)
            step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
